// File: rtl/fir_pkg.sv
// ----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the 2D FIR top level: default pixel and dimension
// widths (the dimension width is reused by the line-buffer controller), the
// default controller pipeline drain depth, and the line sequencer state
// encoding.
// ----------------------------------------------------------------------------
package fir_pkg;

  localparam int unsigned DATA_WIDTH_DEF   = 8;
  localparam int unsigned DIM_WIDTH_DEF    = 12;
  localparam int unsigned DRAIN_CYCLES_DEF = 2;

  // Line sequencer state encoding
  localparam int unsigned      ST_W       = 3;
  localparam logic [ST_W-1:0]  ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0]  ST_LINE    = 3'd1;
  localparam logic [ST_W-1:0]  ST_DRAIN   = 3'd2;
  localparam logic [ST_W-1:0]  ST_RSTADDR = 3'd3;
  localparam logic [ST_W-1:0]  ST_DONE    = 3'd4;

  typedef enum logic [ST_W-1:0] {
    S_IDLE    = ST_IDLE,
    S_LINE    = ST_LINE,
    S_DRAIN   = ST_DRAIN,
    S_RSTADDR = ST_RSTADDR,
    S_DONE    = ST_DONE
  } seq_state_t;

endpackage

// File: rtl/fir_line_sequencer.sv
// ----------------------------------------------------------------------------
// fir_line_sequencer
// Frame sequencer in front of the 2D FIR line-buffer controller. Accepts a
// valid/ready pixel stream for one frame of cfg_width_i x cfg_height_i pixels
// and turns it into controller clock-enables. After every line it issues
// DRAIN_CYCLES flush enables (rd_en=1, data 0) and one address-reset enable
// (rd_en=0), then moves to the next line or reports frame completion.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start_i           frame start request (only honoured in IDLE)
//   abort_i           synchronous abort back to IDLE
//   cfg_width_i       pixels per line (>=2), latched on accepted start
//   cfg_height_i      lines per frame (>=1), latched on accepted start
//   in_valid_i/in_ready_o/in_data_i   pixel stream handshake
//   ce_o, data_pixel_o, first_ln_o, rd_en_o   controller drive (registered)
//   busy_o            frame in progress
//   frame_done_o      one-cycle end-of-frame pulse
//   cfg_err_o         one-cycle pulse on rejected start
//   line_idx_o        current line index
// ----------------------------------------------------------------------------
module fir_line_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned DIM_WIDTH    = DIM_WIDTH_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [DIM_WIDTH-1:0]  cfg_width_i,
  input  logic [DIM_WIDTH-1:0]  cfg_height_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  ce_o,
  output logic [DATA_WIDTH-1:0] data_pixel_o,
  output logic                  first_ln_o,
  output logic                  rd_en_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  cfg_err_o,
  output logic [DIM_WIDTH-1:0]  line_idx_o
);

  localparam int unsigned      DRN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

  // State and configuration
  seq_state_t            r_state;
  seq_state_t            w_state_nxt;
  logic [DIM_WIDTH-1:0]  r_width;
  logic [DIM_WIDTH-1:0]  r_height;
  logic [DIM_WIDTH-1:0]  w_width_nxt;
  logic [DIM_WIDTH-1:0]  w_height_nxt;

  // Counters
  logic [DIM_WIDTH-1:0]  r_pix_cnt;
  logic [DIM_WIDTH-1:0]  r_line_idx;
  logic [DRN_W-1:0]      r_drain_cnt;
  logic [DIM_WIDTH-1:0]  w_pix_cnt_nxt;
  logic [DIM_WIDTH-1:0]  w_line_idx_nxt;
  logic [DRN_W-1:0]      w_drain_cnt_nxt;

  // Registered outputs and their next values
  logic                  r_in_ready;
  logic                  r_ce;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_first_ln;
  logic                  r_rd_en;
  logic                  r_busy;
  logic                  r_frame_done;
  logic                  r_cfg_err;
  logic                  w_ce_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic                  w_first_ln_nxt;
  logic                  w_rd_en_nxt;
  logic                  w_cfg_err_nxt;

  logic                  w_xfer;
  logic                  w_cfg_ok;

  assign w_xfer   = in_valid_i & r_in_ready & (r_state == S_LINE);
  assign w_cfg_ok = (cfg_width_i >= DIM_WIDTH'(2)) && (cfg_height_i != '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, counter updates and controller events for this cycle
  always_comb begin
    w_state_nxt     = r_state;
    w_width_nxt     = r_width;
    w_height_nxt    = r_height;
    w_pix_cnt_nxt   = r_pix_cnt;
    w_line_idx_nxt  = r_line_idx;
    w_drain_cnt_nxt = r_drain_cnt;
    w_ce_nxt        = 1'b0;
    w_data_nxt      = '0;
    w_rd_en_nxt     = 1'b0;
    w_first_ln_nxt  = 1'b0;
    w_cfg_err_nxt   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (w_cfg_ok) begin
            w_width_nxt     = cfg_width_i;
            w_height_nxt    = cfg_height_i;
            w_pix_cnt_nxt   = '0;
            w_line_idx_nxt  = '0;
            w_drain_cnt_nxt = '0;
            w_state_nxt     = S_LINE;
          end else begin
            w_cfg_err_nxt = 1'b1;
          end
        end
      end

      S_LINE: begin
        if (w_xfer) begin
          w_ce_nxt    = 1'b1;
          w_rd_en_nxt = 1'b1;
          w_data_nxt  = in_data_i;
          if (r_pix_cnt == r_width - DIM_WIDTH'(1)) begin
            w_pix_cnt_nxt   = '0;
            w_drain_cnt_nxt = '0;
            w_state_nxt     = S_DRAIN;
          end else begin
            w_pix_cnt_nxt = r_pix_cnt + DIM_WIDTH'(1);
          end
        end
      end

      // Flush the controller pipeline with zero pixels
      S_DRAIN: begin
        w_ce_nxt    = 1'b1;
        w_rd_en_nxt = 1'b1;
        if (r_drain_cnt == DRN_LAST) begin
          w_drain_cnt_nxt = '0;
          w_state_nxt     = S_RSTADDR;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt + DRN_W'(1);
        end
      end

      // Enable with rd_en low rewinds the controller address counter
      S_RSTADDR: begin
        w_ce_nxt = 1'b1;
        if (r_line_idx == r_height - DIM_WIDTH'(1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_line_idx_nxt = r_line_idx + DIM_WIDTH'(1);
          w_state_nxt    = S_LINE;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // line_idx is only advanced on the RSTADDR exit, so line 0's drain and
    // address-reset enables still carry first_ln
    w_first_ln_nxt = w_ce_nxt & (r_line_idx == '0);

    if (abort_i) begin
      w_state_nxt     = S_IDLE;
      w_pix_cnt_nxt   = '0;
      w_line_idx_nxt  = '0;
      w_drain_cnt_nxt = '0;
      w_ce_nxt        = 1'b0;
      w_data_nxt      = '0;
      w_rd_en_nxt     = 1'b0;
      w_first_ln_nxt  = 1'b0;
      w_cfg_err_nxt   = 1'b0;
    end
  end

  // Configuration, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_width      <= '0;
      r_height     <= '0;
      r_pix_cnt    <= '0;
      r_line_idx   <= '0;
      r_drain_cnt  <= '0;
      r_in_ready   <= 1'b0;
      r_ce         <= 1'b0;
      r_data       <= '0;
      r_first_ln   <= 1'b0;
      r_rd_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_width      <= w_width_nxt;
      r_height     <= w_height_nxt;
      r_pix_cnt    <= w_pix_cnt_nxt;
      r_line_idx   <= w_line_idx_nxt;
      r_drain_cnt  <= w_drain_cnt_nxt;
      r_in_ready   <= (w_state_nxt == S_LINE);
      r_ce         <= w_ce_nxt;
      r_data       <= w_data_nxt;
      r_first_ln   <= w_first_ln_nxt;
      r_rd_en      <= w_rd_en_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_frame_done <= (w_state_nxt == S_DONE);
      r_cfg_err    <= w_cfg_err_nxt;
    end
  end

  assign in_ready_o   = r_in_ready;
  assign ce_o         = r_ce;
  assign data_pixel_o = r_data;
  assign first_ln_o   = r_first_ln;
  assign rd_en_o      = r_rd_en;
  assign busy_o       = r_busy;
  assign frame_done_o = r_frame_done;
  assign cfg_err_o    = r_cfg_err;
  assign line_idx_o   = r_line_idx;

endmodule

// File: tb/tb_fir_line_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fir_line_sequencer
// Frame-level bench for fir_line_sequencer. Each frame is planned up front as
// a cycle-indexed schedule: pixel arrival gaps are chosen, transfer cycles
// follow from them, and every line adds DRAIN flush enables plus one
// address-reset enable. The DUT outputs are compared against that schedule
// every cycle; frame-level totals are compared against a vector table.
// ----------------------------------------------------------------------------
module tb_fir_line_sequencer;

  localparam int DW   = 8;
  localparam int NW   = 12;
  localparam int DRN  = 2;
  localparam int MAXC = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          abort_i;
  logic [NW-1:0] cfg_width_i;
  logic [NW-1:0] cfg_height_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic          ce_o;
  logic [DW-1:0] data_pixel_o;
  logic          first_ln_o;
  logic          rd_en_o;
  logic          busy_o;
  logic          frame_done_o;
  logic          cfg_err_o;
  logic [NW-1:0] line_idx_o;

  int checks   = 0;
  int failures = 0;

  fir_line_sequencer #(
    .DATA_WIDTH  (DW),
    .DIM_WIDTH   (NW),
    .DRAIN_CYCLES(DRN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .cfg_width_i  (cfg_width_i),
    .cfg_height_i (cfg_height_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .ce_o         (ce_o),
    .data_pixel_o (data_pixel_o),
    .first_ln_o   (first_ln_o),
    .rd_en_o      (rd_en_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .cfg_err_o    (cfg_err_o),
    .line_idx_o   (line_idx_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic          vld;
    logic [DW-1:0] dat;
    logic          rdy;
    logic          ce;
    logic          rd;
    logic          fl;
    logic [DW-1:0] pix;
    logic          busy;
    logic          done;
    logic [NW-1:0] lidx;
  } cyc_t;

  typedef struct {
    int w;
    int h;
    int mode;     // 0 continuous valid, 1 valid toggling, 2 random gaps
    int exp_ce;
    int exp_fl;
    int exp_rd0;
    int exp_err;  // 1: start must be rejected
  } vec_t;

  cyc_t sch[MAXC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({in_ready_o, ce_o, rd_en_o, first_ln_o, data_pixel_o,
                busy_o, frame_done_o, cfg_err_o, line_idx_o});
  endfunction

  // Plan one legal frame, drive it, compare every cycle, return totals
  task automatic run_frame(input int w, input int h, input int mode,
                           output int n_ce, output int n_fl, output int n_rd0, output int n_done);
    int c, lt, ls, t, g, last;
    logic [DW-1:0] pv;
    logic [63:0]   exp;
    for (int i = 0; i < MAXC; i++) begin
      sch[i].vld  = 1'($urandom_range(0, 1));
      sch[i].dat  = DW'($urandom);
      sch[i].rdy  = 1'b0;
      sch[i].ce   = 1'b0;
      sch[i].rd   = 1'b0;
      sch[i].fl   = 1'b0;
      sch[i].pix  = '0;
      sch[i].busy = 1'b0;
      sch[i].done = 1'b0;
      sch[i].lidx = '0;
    end
    pv = (mode == 1) ? 8'h10 : DW'($urandom);
    c  = 1;
    for (int l = 0; l < h; l++) begin
      ls = c;
      lt = c - 1;
      for (int k = 0; k < w; k++) begin
        g = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
        for (int j = 1; j <= g; j++) sch[lt + j].vld = 1'b0;
        t = lt + g + 1;
        sch[t].vld     = 1'b1;
        sch[t].dat     = pv;
        sch[t + 1].ce  = 1'b1;
        sch[t + 1].rd  = 1'b1;
        sch[t + 1].fl  = (l == 0);
        sch[t + 1].pix = pv;
        pv++;
        lt = t;
      end
      for (int i = ls; i <= lt; i++) sch[i].rdy = 1'b1;
      for (int d = 1; d <= DRN; d++) begin
        sch[lt + 1 + d].ce = 1'b1;
        sch[lt + 1 + d].rd = 1'b1;
        sch[lt + 1 + d].fl = (l == 0);
      end
      sch[lt + DRN + 2].ce = 1'b1;
      sch[lt + DRN + 2].rd = 1'b0;
      sch[lt + DRN + 2].fl = (l == 0);
      for (int i = ls; i <= lt + DRN + 1; i++) sch[i].lidx = NW'(l);
      c = lt + DRN + 2;
    end
    // c is now the DONE cycle
    for (int i = 1; i <= c; i++) sch[i].busy = 1'b1;
    sch[c].done = 1'b1;
    last = c + 2;
    for (int i = c; i <= last; i++) sch[i].lidx = NW'(h - 1);
    if (last >= MAXC) begin
      $display("FAIL schedule: frame too long (%0d cycles) limit %0d", last, MAXC);
      $fatal(1);
    end

    n_ce = 0; n_fl = 0; n_rd0 = 0; n_done = 0;
    abort_i = 1'b0;
    for (int n = 0; n < last; n++) begin
      if (n == 0) begin
        start_i      = 1'b1;
        cfg_width_i  = NW'(w);
        cfg_height_i = NW'(h);
      end else if (n <= c) begin
        // start requests mid-frame must be ignored, whatever the config
        start_i      = 1'($urandom_range(0, 1));
        cfg_width_i  = NW'($urandom_range(0, 9));
        cfg_height_i = NW'($urandom_range(0, 5));
      end else begin
        start_i = 1'b0;
      end
      in_valid_i = sch[n].vld;
      in_data_i  = sch[n].dat;
      tick();
      exp = 64'({sch[n + 1].rdy, sch[n + 1].ce, sch[n + 1].rd, sch[n + 1].fl, sch[n + 1].pix,
                 sch[n + 1].busy, sch[n + 1].done, 1'b0, sch[n + 1].lidx});
      chk($sformatf("frame %0dx%0d cyc %0d {rdy,ce,rd,fl,pix,busy,done,err,lidx}", w, h, n + 1),
          all_outs(), exp);
      if (ce_o)               n_ce++;
      if (ce_o && first_ln_o) n_fl++;
      if (ce_o && !rd_en_o)   n_rd0++;
      if (frame_done_o)       n_done++;
    end
    start_i    = 1'b0;
    in_valid_i = 1'b0;
  endtask

  // Attempt a start with an illegal config and watch a few cycles
  task automatic run_illegal(input int w, input int h, output int n_err, output int n_ce);
    n_err = 0;
    n_ce  = 0;
    start_i      = 1'b1;
    cfg_width_i  = NW'(w);
    cfg_height_i = NW'(h);
    in_valid_i   = 1'b1;
    tick();
    start_i = 1'b0;
    chk($sformatf("illegal %0dx%0d {err,busy,rdy,ce}", w, h),
        64'({cfg_err_o, busy_o, in_ready_o, ce_o}), 64'(4'b1000));
    n_err += int'(cfg_err_o);
    n_ce  += int'(ce_o);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("illegal quiet {err,busy,rdy,ce}", 64'({cfg_err_o, busy_o, in_ready_o, ce_o}), 64'(0));
      n_err += int'(cfg_err_o);
      n_ce  += int'(ce_o);
    end
    in_valid_i = 1'b0;
  endtask

  task automatic frame_totals(input string name, input int n_ce, input int n_fl, input int n_rd0,
                              input int n_done, input int e_ce, input int e_fl, input int e_rd0);
    chk({name, " ce count"}, 64'(n_ce), 64'(e_ce));
    chk({name, " first_ln count"}, 64'(n_fl), 64'(e_fl));
    chk({name, " rd_en=0 count"}, 64'(n_rd0), 64'(e_rd0));
    chk({name, " frame_done count"}, 64'(n_done), 64'(1));
  endtask

  initial begin
    vec_t vecs[7];
    int   n_ce, n_fl, n_rd0, n_done, n_err;
    int   rw, rh;

    vecs[0] = '{4, 3, 0, 21, 7, 3, 0};
    vecs[1] = '{4, 2, 1, 14, 7, 2, 0};
    vecs[2] = '{1, 3, 0,  0, 0, 0, 1};
    vecs[3] = '{2, 0, 0,  0, 0, 0, 1};
    vecs[4] = '{2, 1, 0,  5, 5, 1, 0};
    vecs[5] = '{3, 1, 1,  6, 6, 1, 0};
    vecs[6] = '{5, 2, 2, 16, 8, 2, 0};

    rst          = 1'b1;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    cfg_width_i  = '0;
    cfg_height_i = '0;
    in_valid_i   = 1'b0;
    in_data_i    = '0;
    tick();
    tick();
    chk("reset outputs", all_outs(), 64'(0));
    #2 rst = 1'b0;
    tick();
    chk("idle after reset", all_outs(), 64'(0));

    // Vector table
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].exp_err != 0) begin
        run_illegal(vecs[v].w, vecs[v].h, n_err, n_ce);
        chk($sformatf("vec%0d cfg_err pulses", v), 64'(n_err), 64'(1));
        chk($sformatf("vec%0d ce count", v), 64'(n_ce), 64'(0));
      end else begin
        run_frame(vecs[v].w, vecs[v].h, vecs[v].mode, n_ce, n_fl, n_rd0, n_done);
        frame_totals($sformatf("vec%0d", v), n_ce, n_fl, n_rd0, n_done,
                     vecs[v].exp_ce, vecs[v].exp_fl, vecs[v].exp_rd0);
      end
    end

    // Abort two pixels into line 1 of an 8x4 frame
    in_valid_i = 1'b1;
    for (int n = 0; n < 14; n++) begin
      start_i      = (n == 0);
      cfg_width_i  = NW'(8);
      cfg_height_i = NW'(4);
      in_data_i    = DW'(n);
      tick();
    end
    start_i = 1'b0;
    chk("abort pre {ce,rdy,pix,lidx}", 64'({ce_o, in_ready_o, data_pixel_o, line_idx_o}),
        64'({1'b1, 1'b1, 8'h0d, 12'd1}));
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort next cycle", all_outs(), 64'(0));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort quiet {ce,done,rdy,busy}", 64'({ce_o, frame_done_o, in_ready_o, busy_o}), 64'(0));
    end
    in_valid_i = 1'b0;
    run_frame(4, 3, 0, n_ce, n_fl, n_rd0, n_done);
    frame_totals("post-abort", n_ce, n_fl, n_rd0, n_done, 21, 7, 3);

    // Reset during the first DRAIN cycle of line 0
    in_valid_i = 1'b1;
    for (int n = 0; n < 5; n++) begin
      start_i      = (n == 0);
      cfg_width_i  = NW'(4);
      cfg_height_i = NW'(3);
      in_data_i    = DW'(8'h40 + n);
      tick();
    end
    start_i = 1'b0;
    chk("pre-reset {ce,rdy,busy}", 64'({ce_o, in_ready_o, busy_o}), 64'(3'b101));
    #2 rst = 1'b1;
    #1;
    chk("async reset outputs", all_outs(), 64'(0));
    tick();
    chk("held reset outputs", all_outs(), 64'(0));
    in_valid_i = 1'b0;
    #2 rst = 1'b0;
    tick();
    run_frame(4, 3, 0, n_ce, n_fl, n_rd0, n_done);
    frame_totals("post-reset", n_ce, n_fl, n_rd0, n_done, 21, 7, 3);

    // Random geometry with random valid gaps
    for (int f = 0; f < 8; f++) begin
      rw = int'($urandom_range(2, 6));
      rh = int'($urandom_range(1, 4));
      run_frame(rw, rh, 2, n_ce, n_fl, n_rd0, n_done);
      frame_totals($sformatf("rand%0d %0dx%0d", f, rw, rh), n_ce, n_fl, n_rd0, n_done,
                   rh * (rw + DRN + 1), rw + DRN + 1, rh);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_line_sequencer.md
# fir_line_sequencer

Sequences the 2D FIR line-buffer controller for one frame at a time. Accepts a valid/ready pixel stream and the frame geometry, then drives the controller's clock-enable, pixel, first-line and read-enable inputs. After each line it inserts pipeline-drain and address-reset cycles, and it reports frame completion. It sits between the pixel source and the line-buffer controller in the FIR top level.

## Interface
- DATA_WIDTH, 8, pixel width
- DIM_WIDTH, 12, width of width/height configuration and counters
- DRAIN_CYCLES, 2, enable cycles after each line that flush the controller pipeline (controller latency)
- Clock is `clk`; reset is `rst`, asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start_i  in  1  frame start request; sampled only in IDLE
- abort_i  in  1  synchronous abort; forces IDLE
- cfg_width_i  in  DIM_WIDTH  pixels per line; latched on accepted start; legal ≥2
- cfg_height_i  in  DIM_WIDTH  lines per frame; latched on accepted start; legal ≥1
- in_valid_i  in  1  pixel valid
- in_ready_o  out  1  pixel ready
- in_data_i  in  DATA_WIDTH  pixel
- ce_o  out  1  controller clock enable
- data_pixel_o  out  DATA_WIDTH  pixel to controller
- first_ln_o  out  1  controller first-line select
- rd_en_o  out  1  controller read/output enable
- busy_o  out  1  high from the cycle after accepted start until DONE exits
- frame_done_o  out  1  one-cycle pulse at end of frame
- cfg_err_o  out  1  one-cycle pulse when start is rejected
- line_idx_o  out  DIM_WIDTH  current line index

## Operation
- States: IDLE, LINE, DRAIN, RSTADDR, DONE.
- **IDLE**
  - start_i=1 with width≥2 and height≥1: latch config, clear counters, go to LINE.
  - start_i=1 with illegal config: pulse cfg_err_o next cycle, stay in IDLE.
- **LINE**
  - in_ready_o=1.
  - Transfer = in_valid_i & in_ready_o.
  - Each transfer increments pix_cnt.
  - A transfer with pix_cnt==width-1 goes to DRAIN and clears pix_cnt.
- **DRAIN**
  - Lasts DRAIN_CYCLES cycles; in_ready_o=0.
  - Each cycle issues ce with rd_en=1 and data 0.
- **RSTADDR**
  - One cycle issuing ce with rd_en=0, which resets the controller address counter.
  - If line_idx==height-1, go to DONE; else line_idx+1 and go to LINE.
- **DONE**: one cycle; frame_done_o pulses; go to IDLE.
- Controller outputs are registered from the cycle's events:
  - ce_o=1 the cycle after each transfer, each DRAIN cycle and the RSTADDR cycle; otherwise 0.
  - data_pixel_o holds the transferred pixel on transfer-driven ce and 0 on drain and reset ce.
  - rd_en_o is registered with the same rules.
- first_ln_o=1 for every ce_o issued while line_idx==0, including line 0's DRAIN and RSTADDR. Otherwise 0.
- Arithmetic: counters are DIM_WIDTH unsigned; compares use cfg-1 without wrap, since the config is legal.
- start_i while not in IDLE is ignored.
- abort_i has priority over everything except rst. Next cycle: IDLE, in_ready_o=0, no ce_o, no frame_done_o, counters cleared.

## Timing
- Reset values:
  - state IDLE
  - in_ready_o, ce_o, first_ln_o, rd_en_o, busy_o, frame_done_o, cfg_err_o = 0
  - data_pixel_o = 0, line_idx_o = 0
- Cycle c start accepted → state LINE and in_ready_o=1 at c+1.
- Transfer at cycle t → ce_o=1 with data_pixel_o=in_data_i at t+1.
- Per line: ce_o count = width + DRAIN_CYCLES + 1. No stall inside DRAIN or RSTADDR.
- Last line RSTADDR at cycle r → frame_done_o=1 at r+1; busy_o falls at r+2.
- Back-pressure: in_valid_i gaps produce ce_o gaps only. Controller state is held by ce.
- rst mid-frame: all outputs return to reset values asynchronously, and no partial ce is issued.

## Structure
- Package fir_pkg holds:
  - state encoding localparams (IDLE..DONE)
  - DRAIN_CYCLES default
  - a shared DIM_WIDTH default, reused by the line-buffer controller instantiation
- No sub-module is required. The pix, line and drain counters are inline.

## Test plan
- **Nominal frame**: width=4, height=3, continuous valid.
  - 12 transfers and 21 ce_o pulses.
  - first_ln_o on the first 7 ce_o pulses.
  - rd_en_o=0 on ce pulses 7, 14, 21.
  - frame_done_o one pulse; busy_o low afterwards.
- **Back-pressure**: width=4, height=2, in_valid_i toggling every cycle.
  - ce_o appears exactly one cycle after each transfer.
  - data_pixel_o sequence equals the input order (e.g. 0x10..0x17).
  - Total 14 ce_o pulses.
- **Illegal config**: start with width=1.
  - cfg_err_o pulses once; busy_o stays 0; no ce_o.
  - Then start with width=2, height=1: 5 ce_o pulses, all first_ln_o=1.
- **Abort**: abort_i asserted after 2 pixels of line 1 (width=8, height=4).
  - Next cycle: IDLE, in_ready_o=0, no further ce_o, no frame_done_o.
  - A new start then completes normally.
- **Reset mid-DRAIN**: rst asserted.
  - All outputs 0 immediately; line_idx_o=0.
  - A post-reset frame matches the nominal frame.
- **Start while busy**: start_i pulsed during LINE is ignored; config changes are not picked up until the next IDLE start.
